// File: rtl/regfile_param_if.sv
// Bus bundle for the parametrised register file: two read ports, one write
// port, bulk-clear handshake and the addressed debug readout.
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output a_addr, b_addr, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
    input  a_data, b_data, busy, wr_drop, dbg_data
  );

  modport slave (
    input  a_addr, b_addr, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
    output a_data, b_data, busy, wr_drop, dbg_data
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with optional zero R0, write-to-read
// bypass, a sequential bulk-clear engine and a raw debug readout port.
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_param_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cnt_r;
  logic              wr_drop_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              wr_ok_s;
  logic              byp_en_s;
  logic [DATA_W-1:0] a_data_s;
  logic [DATA_W-1:0] b_data_s;

  // Write qualification and bypass enable (bypass only while the engine is idle)
  always_comb begin
    wr_ok_s  = rf.wr_en;
    byp_en_s = 1'b0;
    if ((ZERO_R0 != 0) && (rf.wr_addr == ADDR_ZERO)) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = rf.wr_en;
    end
    if ((BYPASS != 0) && rf.wr_en && (state_r == ST_IDLE)) begin
      byp_en_s = 1'b1;
    end else begin
      byp_en_s = 1'b0;
    end
  end

  // Clear FSM, clear counter, dropped-write flag and the storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {ADDR_W{1'b0}};
      wr_drop_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          wr_drop_r <= 1'b0;
          // A write coinciding with clr_req still lands; the sweep clears it later.
          if (wr_ok_s) begin
            mem_r[rf.wr_addr] <= rf.wr_data;
          end
          if (rf.clr_req) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_W{1'b0}};
          end
        end
        ST_CLEAR: begin
          mem_r[cnt_r] <= {DATA_W{1'b0}};
          cnt_r        <= cnt_r + 1'b1;
          wr_drop_r    <= rf.wr_en;
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= {ADDR_W{1'b0}};
          wr_drop_r <= 1'b0;
        end
      endcase
    end
  end

  // Read ports: zero-R0 has priority over bypass, bypass over storage
  always_comb begin
    a_data_s = mem_r[rf.a_addr];
    b_data_s = mem_r[rf.b_addr];
    if ((ZERO_R0 != 0) && (rf.a_addr == ADDR_ZERO)) begin
      a_data_s = {DATA_W{1'b0}};
    end else if (byp_en_s && (rf.a_addr == rf.wr_addr)) begin
      a_data_s = rf.wr_data;
    end else begin
      a_data_s = mem_r[rf.a_addr];
    end
    if ((ZERO_R0 != 0) && (rf.b_addr == ADDR_ZERO)) begin
      b_data_s = {DATA_W{1'b0}};
    end else if (byp_en_s && (rf.b_addr == rf.wr_addr)) begin
      b_data_s = rf.wr_data;
    end else begin
      b_data_s = mem_r[rf.b_addr];
    end
  end

  assign rf.a_data   = a_data_s;
  assign rf.b_data   = b_data_s;
  assign rf.dbg_data = mem_r[rf.dbg_addr];
  assign rf.busy     = (state_r == ST_CLEAR);
  assign rf.wr_drop  = wr_drop_r;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default, no-bypass and zero-R0 instances, driven
// from vector tables and hand sequences, checked through an expected-value queue.
module tb_regfile_param;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_def ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_nb ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_z ();

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0), .BYPASS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .rf(if_def));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rf(if_nb));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1), .BYPASS(1)) u_z (
    .clk(clk), .rst_n(rst_n), .rf(if_z));

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [3:0]  da;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ed;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[6];
  logic [15:0] mdl[DEPTH];
  logic [15:0] pre[DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic sb_push(input string n, input logic [15:0] e);
    sb_t r;
    r.name = n;
    r.exp  = e;
    sb_q.push_back(r);
  endtask

  task automatic sb_pop(input logic [15:0] act);
    sb_t r;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: actual %h with no expectation queued", act);
    end else begin
      r = sb_q.pop_front();
      if (act !== r.exp) begin
        errors++;
        $display("FAIL %s: actual %h expected %h", r.name, act, r.exp);
      end
    end
  endtask

  // Inputs change 1 ns after the rising edge, outputs are sampled 4 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_def();
    if_def.wr_en = 1'b0; if_def.wr_addr = 4'd0; if_def.wr_data = 16'h0000;
    if_def.a_addr = 4'd0; if_def.b_addr = 4'd0; if_def.dbg_addr = 4'd0;
    if_def.clr_req = 1'b0;
  endtask

  task automatic readback_all(input string tag);
    idle_def();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if_def.a_addr   = 4'(i);
      if_def.b_addr   = 4'(15 - i);
      if_def.dbg_addr = 4'(i);
      sb_push({tag, "_a"}, mdl[i]);
      sb_push({tag, "_b"}, mdl[15 - i]);
      sb_push({tag, "_dbg"}, mdl[i]);
      settle();
      sb_pop(if_def.a_data);
      sb_pop(if_def.b_data);
      sb_pop(if_def.dbg_data);
    end
  endtask

  function automatic logic [15:0] clr_exp(input int k, input int c);
    if (c >= 16 || k < c) return 16'h0000;
    return pre[k];
  endfunction

  initial begin
    vecs[0] = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5,  4'd5, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 4'd3, 16'h1111, 4'd5, 4'd3,  4'd5, 16'hBEEF, 16'h1111, 16'hBEEF};
    vecs[2] = '{1'b0, 4'd3, 16'h2222, 4'd3, 4'd0,  4'd3, 16'h1111, 16'h0000, 16'h1111};
    vecs[3] = '{1'b1, 4'd0, 16'h0A0A, 4'd0, 4'd4,  4'd0, 16'h0A0A, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 4'd5, 16'hCAFE, 4'd5, 4'd0,  4'd0, 16'hCAFE, 16'h0A0A, 16'h0A0A};
    vecs[5] = '{1'b0, 4'd5, 16'h0000, 4'd5, 4'd15, 4'd5, 16'hCAFE, 16'h0000, 16'hCAFE};

    idle_def();
    if_nb.wr_en = 1'b0; if_nb.wr_addr = 4'd0; if_nb.wr_data = 16'h0000;
    if_nb.a_addr = 4'd0; if_nb.b_addr = 4'd0; if_nb.dbg_addr = 4'd0; if_nb.clr_req = 1'b0;
    if_z.wr_en = 1'b0; if_z.wr_addr = 4'd0; if_z.wr_data = 16'h0000;
    if_z.a_addr = 4'd0; if_z.b_addr = 4'd0; if_z.dbg_addr = 4'd0; if_z.clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;

    repeat (2) step();
    rst_n = 1'b1;

    // Reset mid-run: store a value, then pull rst_n low between edges
    step();
    if_def.wr_en = 1'b1; if_def.wr_addr = 4'd6; if_def.wr_data = 16'h6666; if_def.dbg_addr = 4'd6;
    step();
    if_def.wr_en = 1'b0;
    sb_push("pre_rst_r6", 16'h6666);
    settle();
    sb_pop(if_def.dbg_data);
    #2 rst_n = 1'b0;
    #1;
    sb_push("rst_busy", 16'h0000);
    sb_push("rst_wr_drop", 16'h0000);
    sb_push("rst_r6", 16'h0000);
    sb_pop({15'h0, if_def.busy});
    sb_pop({15'h0, if_def.wr_drop});
    sb_pop(if_def.dbg_data);
    step();
    step();
    #2 rst_n = 1'b1;
    readback_all("rst_rb");

    // Table-driven writes, bypass and debug readout on the default instance
    for (int i = 0; i < 6; i++) begin
      step();
      if_def.wr_en    = vecs[i].we;
      if_def.wr_addr  = vecs[i].wa;
      if_def.wr_data  = vecs[i].wd;
      if_def.a_addr   = vecs[i].aa;
      if_def.b_addr   = vecs[i].ba;
      if_def.dbg_addr = vecs[i].da;
      sb_push($sformatf("vec%0d_a", i), vecs[i].ea);
      sb_push($sformatf("vec%0d_b", i), vecs[i].eb);
      sb_push($sformatf("vec%0d_dbg", i), vecs[i].ed);
      settle();
      sb_pop(if_def.a_data);
      sb_pop(if_def.b_data);
      sb_pop(if_def.dbg_data);
      if (vecs[i].we) mdl[vecs[i].wa] = vecs[i].wd;
    end
    idle_def();

    // No-bypass instance: the new value appears only after the edge
    step();
    if_nb.wr_en = 1'b1; if_nb.wr_addr = 4'd5; if_nb.wr_data = 16'hBEEF; if_nb.a_addr = 4'd5;
    sb_push("nb_write_cycle_a", 16'h0000);
    settle();
    sb_pop(if_nb.a_data);
    step();
    if_nb.wr_en = 1'b0;
    sb_push("nb_next_cycle_a", 16'hBEEF);
    settle();
    sb_pop(if_nb.a_data);

    // Zero-R0 instance: R0 write discarded silently, other registers normal
    step();
    if_z.wr_en = 1'b1; if_z.wr_addr = 4'd0; if_z.wr_data = 16'h1234;
    if_z.a_addr = 4'd0; if_z.b_addr = 4'd0;
    sb_push("z_r0_bypass_a", 16'h0000);
    sb_push("z_r0_bypass_b", 16'h0000);
    settle();
    sb_pop(if_z.a_data);
    sb_pop(if_z.b_data);
    step();
    if_z.wr_addr = 4'd1; if_z.wr_data = 16'h7777; if_z.a_addr = 4'd1; if_z.dbg_addr = 4'd0;
    sb_push("z_r1_bypass_a", 16'h7777);
    sb_push("z_r0_b", 16'h0000);
    sb_push("z_r0_dbg", 16'h0000);
    sb_push("z_wr_drop", 16'h0000);
    settle();
    sb_pop(if_z.a_data);
    sb_pop(if_z.b_data);
    sb_pop(if_z.dbg_data);
    sb_pop({15'h0, if_z.wr_drop});
    step();
    if_z.wr_en = 1'b0; if_z.dbg_addr = 4'd1;
    sb_push("z_r1_dbg", 16'h7777);
    settle();
    sb_pop(if_z.dbg_data);

    // Bulk clear: fill, then request clear together with a write to R15
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if_def.wr_en = 1'b1; if_def.wr_addr = 4'(i); if_def.wr_data = 16'h00AA + 16'(i);
      mdl[i] = 16'h00AA + 16'(i);
    end
    step();
    if_def.wr_addr = 4'd15; if_def.wr_data = 16'h0F0F; if_def.clr_req = 1'b1;
    if_def.a_addr = 4'd3; if_def.b_addr = 4'd4; if_def.dbg_addr = 4'd15;
    mdl[15] = 16'h0F0F;
    for (int i = 0; i < DEPTH; i++) pre[i] = mdl[i];
    sb_push("clr_req_cycle_busy", 16'h0000);
    settle();
    sb_pop({15'h0, if_def.busy});
    for (int c = 0; c < 18; c++) begin
      step();
      if_def.clr_req = (c < 15);
      if_def.wr_en   = (c == 2);
      if_def.wr_addr = 4'd2;
      if_def.wr_data = 16'h5555;
      if_def.a_addr  = (c == 2) ? 4'd2 : 4'd3;
      if (c == 16) begin
        if_def.wr_en = 1'b1; if_def.wr_addr = 4'd9; if_def.wr_data = 16'h9999; if_def.a_addr = 4'd9;
      end
      sb_push($sformatf("clr%0d_busy", c), {15'h0, (c < 16)});
      sb_push($sformatf("clr%0d_a", c),
              (c == 16) ? 16'h9999 : clr_exp((c == 2) ? 2 : 3, c));
      sb_push($sformatf("clr%0d_r4", c), clr_exp(4, c));
      sb_push($sformatf("clr%0d_r15", c), clr_exp(15, c));
      sb_push($sformatf("clr%0d_wr_drop", c), {15'h0, (c == 3)});
      settle();
      sb_pop({15'h0, if_def.busy});
      sb_pop(if_def.a_data);
      sb_pop(if_def.b_data);
      sb_pop(if_def.dbg_data);
      sb_pop({15'h0, if_def.wr_drop});
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
    mdl[9] = 16'h9999;
    readback_all("post_clr");

    // Reset during clear cycle 7
    step();
    if_def.wr_en = 1'b1; if_def.wr_addr = 4'd8; if_def.wr_data = 16'h8888;
    step();
    if_def.wr_en = 1'b0; if_def.clr_req = 1'b1;
    step();
    if_def.clr_req = 1'b0;
    repeat (7) step();
    if_def.a_addr = 4'd8;
    sb_push("mid_clr_busy", 16'h0001);
    sb_push("mid_clr_r8", 16'h8888);
    #1;
    sb_pop({15'h0, if_def.busy});
    sb_pop(if_def.a_data);
    #1 rst_n = 1'b0;
    #1;
    sb_push("mid_rst_busy", 16'h0000);
    sb_push("mid_rst_r8", 16'h0000);
    sb_push("mid_rst_wr_drop", 16'h0000);
    sb_pop({15'h0, if_def.busy});
    sb_pop(if_def.a_data);
    sb_pop({15'h0, if_def.wr_drop});
    step();
    step();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      sb_push($sformatf("post_rst%0d_busy", c), 16'h0000);
      settle();
      sb_pop({15'h0, if_def.busy});
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
    readback_all("post_rst");

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: actual %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file, successor to the fixed 16x16 two-read/one-write file in the datapath. Width and depth are generics. It adds four things the fixed file lacks: an asynchronous reset, optional hard-wired-zero R0, write-to-read bypass, and a sequential bulk-clear engine. It also keeps the debug readout path, now as an addressed port. It sits between decode (read addresses) and writeback (write port) in the core.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_addr  in  ADDR_W  read port A address
- b_addr  in  ADDR_W  read port B address
- a_data  out  DATA_W  read port A data, combinational
- b_data  out  DATA_W  read port B data, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  bulk-clear request, level-sampled
- busy  out  1  clear engine active
- wr_drop  out  1  registered one-cycle pulse: the previous cycle's write was dropped
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data; raw storage, no bypass

## Operation
- Storage: DEPTH x DATA_W flops.
- Reset (rst_n low, asynchronous): all registers 0, state IDLE, clear counter 0, busy 0, wr_drop 0.
- Write (IDLE state):
  - wr_en=1 writes wr_data to reg[wr_addr] at the rising edge.
  - With ZERO_R0=1, writes to address 0 are discarded silently, with no wr_drop.
- Read, A and B identical and independent:
  - Base value is reg[addr].
  - With ZERO_R0=1, address 0 returns 0. This check takes priority over bypass.
  - With BYPASS=1, the port returns wr_data when wr_en=1, busy=0, and addr==wr_addr.
- The FSM has two states, IDLE and CLEAR.
- IDLE:
  - clr_req=1 at an edge moves to CLEAR with cnt=0.
  - A write present in that same cycle is still performed.
- CLEAR:
  - Each edge sets reg[cnt] to 0 and increments cnt.
  - After the edge with cnt==DEPTH-1, return to IDLE; cnt wraps to 0.
  - clr_req is ignored while in CLEAR, with no re-trigger.
  - wr_en=1 is ignored and wr_drop=1 on the next cycle.
  - Reads return current storage, possibly partially cleared. Bypass is disabled.
- busy = (state==CLEAR), driven from the state flop.
- Arithmetic: cnt is ADDR_W bits and wraps naturally at DEPTH-1. There are no width conversions; all data paths are DATA_W.

## Timing
- Read latency: 0 cycles, combinational from address.
- Write visibility:
  - Storage updates at the edge.
  - Through bypass, the value is visible in the same cycle as wr_en.
  - Without bypass, it is visible the cycle after.
- Clear timing:
  - clr_req sampled at edge N sets busy=1 from edge N.
  - busy stays high for exactly DEPTH cycles and falls at edge N+DEPTH.
  - The first write accepted after a clear is in the cycle where busy=0 again.
- Clear order: reg[k] reads 0 from edge N+1+k.
- wr_drop: asserted for one cycle after each dropped write, then deasserted.
- Reset mid-clear: immediate return to IDLE, busy=0, all registers 0. No clear resumes after reset release.
- Simultaneous clr_req and wr_en in IDLE: the write lands, then is cleared in its turn.
- Same-cycle equal addresses: both read ports may target the same register, or the write address, with no conflict.

## Test plan
1. Reset and readback:
   - Drive rst_n low mid-run, then release.
   - a_data, b_data and dbg_data read 0 for all 16 addresses; busy=0; wr_drop=0.
2. Write and bypass (defaults):
   - Write 0xBEEF to R5 with a_addr=5.
   - a_data=0xBEEF in the same cycle and dbg_data(5)=0xBEEF after the edge.
   - With BYPASS=0, a_data=0x0000 in the write cycle.
3. ZERO_R0=1:
   - Write 0x1234 to R0.
   - a_data(0)=0 and dbg_data(0)=0; wr_drop stays 0.
4. Bulk clear:
   - Fill R0..R15 with 0x00AA+i, pulse clr_req one cycle.
   - busy is high 16 cycles.
   - R3 reads 0 from edge N+4 while R4 still reads 0x00AE.
   - After the clear, all registers read 0.
5. Write during clear:
   - wr_en to R2 with 0x5555 while busy.
   - wr_drop=1 next cycle and R2 reads 0 after the clear.
   - clr_req held high throughout causes no second clear unless still high when busy falls.
6. Reset mid-clear:
   - Assert rst_n low at clear cycle 7.
   - busy drops immediately and all registers read 0.
   - After release, busy stays 0.
